// File: rtl/scalar_tiled.sv
// scalar_tiled: element-wise Q(IL.FL) vector unit, LANES elements per beat over SIZE/LANES beats.
// Build option SCALAR_ROUND_EN: mul rounds half up, div rounds half away from zero (else truncation).
module scalar_tiled #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int SIZE  = 16,
    parameter int LANES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 mode,
    input  logic                       input_ready,
    input  logic                       output_taken,
    input  logic [SIZE-1:0][IL+FL-1:0] in1,
    input  logic [SIZE-1:0][IL+FL-1:0] in2,
    output logic [1:0]                 state,
    output logic [SIZE-1:0][IL+FL-1:0] out,
    output logic                       div_zero
);
    localparam int W     = IL + FL;
    localparam int WX    = 2 * W + 2;
    localparam int BEATS = SIZE / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic signed [WX-1:0] SAT_MAX = {{(WX-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [WX-1:0] SAT_MIN = {{(WX-W+1){1'b1}}, {(W-1){1'b0}}};
`ifdef SCALAR_ROUND_EN
    localparam logic signed [WX-1:0] MUL_RND = {{(WX-FL){1'b0}}, 1'b1, {(FL-1){1'b0}}};
    localparam logic signed [WX-1:0] ONE_X   = {{(WX-1){1'b0}}, 1'b1};
`else
    localparam logic signed [WX-1:0] MUL_RND = '0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPUTE = 2'b01,
        DONE    = 2'b10
    } state_t;

    genvar gi, gj;

    if ((SIZE % LANES) != 0) begin : g_bad_lanes
        $error("scalar_tiled: LANES must divide SIZE");
    end

    state_t                   state_reg;
    logic [SIZE-1:0][W-1:0]   op_a_reg;
    logic [SIZE-1:0][W-1:0]   op_b_reg;
    logic [SIZE-1:0][W-1:0]   out_reg;
    logic [SIZE-1:0][W-1:0]   out_next;
    logic [2:0]               mode_reg;
    logic [BW-1:0]            beat_reg;
    logic                     div_zero_reg;
    logic [W-1:0]             lane_res [LANES];
    logic [LANES-1:0]         lane_dz;

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W-1:0]         a_beats [BEATS];
            logic [W-1:0]         b_beats [BEATS];
            logic signed [W-1:0]  a;
            logic signed [W-1:0]  b;
            logic signed [WX-1:0] ax;
            logic signed [WX-1:0] bx;
            logic signed [WX-1:0] wide;
            logic                 dz;
`ifdef SCALAR_ROUND_EN
            logic signed [WX-1:0] na;
            logic signed [WX-1:0] nb;
            logic signed [WX-1:0] q;
`endif

            // Lane gi always handles element beat*LANES+gi of the current beat.
            for (gj = 0; gj < BEATS; gj++) begin : g_beat
                assign a_beats[gj] = op_a_reg[gj*LANES + gi];
                assign b_beats[gj] = op_b_reg[gj*LANES + gi];
            end
            assign a = a_beats[beat_reg];
            assign b = b_beats[beat_reg];

            always_comb begin
                ax   = WX'(a);
                bx   = WX'(b);
                wide = '0;
                dz   = 1'b0;
`ifdef SCALAR_ROUND_EN
                na   = '0;
                nb   = '0;
                q    = '0;
`endif
                case (mode_reg)
                    3'b000: wide = ax + bx;
                    3'b001: wide = ax - bx;
                    3'b010: wide = ((ax * bx) + MUL_RND) >>> FL;
                    3'b011: begin
                        if (b == '0) begin
                            dz   = 1'b1;
                            wide = a[W-1] ? SAT_MIN : SAT_MAX;
                        end else begin
`ifdef SCALAR_ROUND_EN
                            // One extra quotient bit on magnitudes, +1, drop it; sign restored after.
                            na   = a[W-1] ? -ax : ax;
                            nb   = b[W-1] ? -bx : bx;
                            q    = (((na <<< (FL + 1)) / nb) + ONE_X) >>> 1;
                            wide = (a[W-1] ^ b[W-1]) ? -q : q;
`else
                            wide = (ax <<< FL) / bx;
`endif
                        end
                    end
                    3'b100: wide = (a > b) ? ax : bx;
                    3'b101: wide = (a < b) ? ax : bx;
                    3'b110: wide = a[W-1] ? '0 : ax;
                    default: wide = ax;
                endcase
            end

            assign lane_res[gi] = (wide > SAT_MAX) ? SAT_MAX[W-1:0] :
                                  (wide < SAT_MIN) ? SAT_MIN[W-1:0] : wide[W-1:0];
            assign lane_dz[gi]  = dz;
        end

        for (gi = 0; gi < SIZE; gi++) begin : g_elem
            assign out_next[gi] = (beat_reg == BW'(gi / LANES)) ? lane_res[gi % LANES] : out_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            out_reg      <= '0;
            div_zero_reg <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            beat_reg     <= '0;
            mode_reg     <= 3'b000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (input_ready) begin
                        op_a_reg     <= in1;
                        op_b_reg     <= in2;
                        mode_reg     <= mode;
                        div_zero_reg <= 1'b0;
                        beat_reg     <= '0;
                        state_reg    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    out_reg <= out_next;
                    if (|lane_dz) begin
                        div_zero_reg <= 1'b1;
                    end
                    if (beat_reg == LAST_BEAT) begin
                        beat_reg  <= '0;
                        state_reg <= DONE;
                    end else begin
                        beat_reg <= beat_reg + BW'(1);
                    end
                end
                DONE: begin
                    // div_zero deliberately survives the hand-off until the next acceptance.
                    if (output_taken) begin
                        out_reg   <= '0;
                        op_a_reg  <= '0;
                        op_b_reg  <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign state    = state_reg;
    assign out      = out_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_scalar_tiled.sv
// tb_scalar_tiled: randomized and directed checks of scalar_tiled against an arithmetic reference model.
module tb_scalar_tiled;
    localparam int IL    = 4;
    localparam int FL    = 16;
    localparam int SIZE  = 16;
    localparam int LANES = 4;
    localparam int W     = IL + FL;
    localparam int BEATS = SIZE / LANES;
    localparam int CW    = SIZE * W;
    localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W - 1));

    typedef logic [SIZE-1:0][W-1:0] vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mode;
    logic       input_ready;
    logic       output_taken;
    vec_t       in1;
    vec_t       in2;
    logic [1:0] state;
    vec_t       out_v;
    logic       div_zero;

    int   tests = 0;
    int   fails = 0;
    vec_t last_out;
    logic last_dz;

    always #5 clk = ~clk;

    scalar_tiled #(.IL(IL), .FL(FL), .SIZE(SIZE), .LANES(LANES)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .input_ready (input_ready),
        .output_taken(output_taken),
        .in1         (in1),
        .in2         (in2),
        .state       (state),
        .out         (out_v),
        .div_zero    (div_zero)
    );

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: real fixed-point semantics on 64-bit integers, element by element.
    function automatic void model(input logic [2:0] m, input vec_t a, input vec_t b,
                                  output vec_t r, output logic dz);
        longint x, y, p, v, mag, t;
        dz = 1'b0;
        r  = '0;
        for (int i = 0; i < SIZE; i++) begin
            x = longint'($signed(a[i]));
            y = longint'($signed(b[i]));
            v = 0;
            case (m)
                3'd0: v = x + y;
                3'd1: v = x - y;
                3'd2: begin
                    p = x * y;
`ifdef SCALAR_ROUND_EN
                    p = p + (longint'(1) <<< (FL - 1));
`endif
                    v = p >>> FL;
                end
                3'd3: begin
                    if (y == 0) begin
                        dz = 1'b1;
                        v  = (x >= 0) ? MAXV : MINV;
                    end else begin
`ifdef SCALAR_ROUND_EN
                        mag = (labs(x) * (longint'(1) <<< (FL + 1))) / labs(y);
                        mag = (mag + 1) / 2;
                        v   = ((x < 0) != (y < 0)) ? -mag : mag;
`else
                        v = (x * (longint'(1) <<< FL)) / y;
`endif
                    end
                end
                3'd4: v = (x > y) ? x : y;
                3'd5: v = (x < y) ? x : y;
                3'd6: v = (x < 0) ? 0 : x;
                default: v = x;
            endcase
            t    = sat(v);
            r[i] = t[W-1:0];
        end
    endfunction

    function automatic vec_t fill(input logic [W-1:0] e);
        vec_t r;
        for (int i = 0; i < SIZE; i++) r[i] = e;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_elem();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(MAXV);
            2: return W'(MINV);
            3: return {{(W-FL){r[31]}}, r[FL-1:0]};
            default: return r[W-1:0];
        endcase
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < SIZE; i++) r[i] = rand_elem();
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input string name, input logic [2:0] m, input vec_t a, input vec_t b);
        vec_t exp;
        logic exp_dz;
        int   beats;
        model(m, a, b, exp, exp_dz);
        @(negedge clk);
        in1 = a;
        in2 = b;
        mode = m;
        input_ready = 1'b1;
        step();
        check({name, ".accept"}, CW'(state), CW'(2'b01));
        // Operands change and input_ready stays high while busy; neither may disturb the result.
        in1  = rand_vec();
        in2  = rand_vec();
        mode = 3'($urandom);
        beats = 0;
        while (state != 2'b10 && beats < 20) begin
            step();
            beats++;
        end
        check({name, ".latency"}, CW'(beats), CW'(BEATS));
        check({name, ".out"}, out_v, exp);
        check({name, ".dz"}, CW'(div_zero), CW'(exp_dz));
        last_out = out_v;
        last_dz  = div_zero;
        step();
        step();
        check({name, ".hold_state"}, CW'(state), CW'(2'b10));
        check({name, ".hold_out"}, out_v, exp);
        @(negedge clk);
        input_ready  = 1'b0;
        output_taken = 1'b1;
        step();
        output_taken = 1'b0;
        check({name, ".taken_state"}, CW'(state), CW'(2'b00));
        check({name, ".taken_out"}, out_v, '0);
        check({name, ".taken_dz"}, CW'(div_zero), CW'(exp_dz));
        $display("[TB] txn %s mode=%0d out0=%05h dz=%0d", name, m, last_out[0], last_dz);
    endtask

    initial begin
        vec_t a;
        vec_t b;
        int   beats;
        reset        = 1'b1;
        input_ready  = 1'b0;
        output_taken = 1'b0;
        mode         = 3'b000;
        in1          = '0;
        in2          = '0;
        step();
        step();
        check("reset.state", CW'(state), CW'(2'b00));
        check("reset.out", out_v, '0);
        check("reset.dz", CW'(div_zero), CW'(1'b0));
        @(negedge clk);
        reset = 1'b0;

        run_txn("add", 3'b000, fill(20'h18000), fill(20'h20000));
        check("add.e0", CW'(last_out[0]), CW'(20'h38000));
        run_txn("sat_add", 3'b000, fill(20'h70000), fill(20'h20000));
        check("sat_add.e0", CW'(last_out[0]), CW'(20'h7FFFF));
        run_txn("sat_sub", 3'b001, fill(20'h90000), fill(20'h20000));
        check("sat_sub.e0", CW'(last_out[0]), CW'(20'h80000));
        run_txn("mul", 3'b010, fill(20'h18000), fill(20'h20000));
        check("mul.e0", CW'(last_out[0]), CW'(20'h30000));
        b    = fill(20'h20000);
        b[5] = '0;
        run_txn("div", 3'b011, fill(20'h10000), b);
        check("div.e0", CW'(last_out[0]), CW'(20'h08000));
        check("div.e5", CW'(last_out[5]), CW'(20'h7FFFF));
        check("div.e6", CW'(last_out[6]), CW'(20'h08000));
        check("div.dz", CW'(last_dz), CW'(1'b1));
        run_txn("max", 3'b100, fill(20'hF0000), fill(20'h10000));
        check("max.e0", CW'(last_out[0]), CW'(20'h10000));
        run_txn("min", 3'b101, fill(20'hF0000), fill(20'h10000));
        check("min.e0", CW'(last_out[0]), CW'(20'hF0000));
        run_txn("relu", 3'b110, fill(20'hF0000), fill(20'h10000));
        check("relu.e0", CW'(last_out[0]), CW'(20'h00000));
        run_txn("round", 3'b010, fill(20'h00001), fill(20'h08000));
`ifdef SCALAR_ROUND_EN
        check("round.e0", CW'(last_out[0]), CW'(20'h00001));
`else
        check("round.e0", CW'(last_out[0]), CW'(20'h00000));
`endif

        // Abort a divide-by-zero transaction after two beats.
        @(negedge clk);
        in1 = rand_vec();
        in2 = '0;
        mode = 3'b011;
        input_ready = 1'b1;
        step();
        input_ready = 1'b0;
        step();
        step();
        check("abort.mid_state", CW'(state), CW'(2'b01));
        check("abort.mid_dz", CW'(div_zero), CW'(1'b1));
        @(negedge clk);
        reset = 1'b1;
        step();
        check("abort.state", CW'(state), CW'(2'b00));
        check("abort.out", out_v, '0);
        check("abort.dz", CW'(div_zero), CW'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        beats = 0;
        run_txn("after_abort", 3'b000, fill(20'h18000), fill(20'h20000));

        for (int n = 0; n < 40; n++) begin
            a = rand_vec();
            b = rand_vec();
            if ($urandom_range(0, 3) == 0) b[$urandom_range(0, SIZE - 1)] = '0;
            run_txn($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
